// File: rtl/switch_rr_scheduler_if.sv
// Handshake bundle between the input FIFOs, the scheduler and the crossbar.
// Scheduler side is the slave; FIFO/crossbar side drives as master.
interface switch_rr_scheduler_if #(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS)
);
  logic [N_PORTS-1:0]        head_valid;
  logic [N_PORTS*PORT_W-1:0] head_dest;
  logic [N_PORTS-1:0]        head_eop;
  logic [N_PORTS-1:0]        out_ready;
  logic [N_PORTS*PORT_W-1:0] sel;
  logic [N_PORTS-1:0]        en;
  logic [N_PORTS-1:0]        rdreq;

  modport master (
    output head_valid, head_dest, head_eop, out_ready,
    input  sel, en, rdreq
  );

  modport slave (
    input  head_valid, head_dest, head_eop, out_ready,
    output sel, en, rdreq
  );
endinterface

// File: rtl/switch_rr_scheduler.sv
// Per-output round-robin scheduler for the N-port switch crossbar.
// Each output locks to one input for a whole packet, released on eop.
module switch_rr_scheduler #(
  parameter int N_PORTS = 4,
  parameter int PORT_W  = $clog2(N_PORTS)
) (
  input logic                 clk,
  input logic                 reset,
  switch_rr_scheduler_if.slave bus
);

  logic [N_PORTS-1:0] busy;
  logic [PORT_W-1:0]  owner   [N_PORTS];
  logic [PORT_W-1:0]  ptr     [N_PORTS];
  logic [PORT_W-1:0]  gnt_idx [N_PORTS];
  logic [N_PORTS-1:0] req     [N_PORTS];
  logic [N_PORTS-1:0] own_map [N_PORTS];
  logic [N_PORTS-1:0] locked;
  logic [N_PORTS-1:0] gnt_vld;
  logic [N_PORTS-1:0] xfer;
  logic [N_PORTS-1:0] done;

  // own_map[i][o]: output o currently owns input i
  always_comb begin
    locked = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      own_map[i] = '0;
    end
    for (int o = 0; o < N_PORTS; o++) begin
      if (busy[o]) begin
        locked[owner[o]]     = 1'b1;
        own_map[owner[o]][o] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int o = 0; o < N_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < N_PORTS; i++) begin
        req[o][i] = bus.head_valid[i] && !locked[i] &&
          (bus.head_dest[i*PORT_W +: PORT_W] == PORT_W'(o));
      end
    end
  end

  // Scan from the top down so the candidate nearest ptr wins
  always_comb begin
    logic [PORT_W-1:0] idx;
    idx = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      gnt_vld[o] = 1'b0;
      gnt_idx[o] = '0;
      for (int k = N_PORTS - 1; k >= 0; k--) begin
        idx = ptr[o] + PORT_W'(k);
        if (req[o][idx]) begin
          gnt_vld[o] = 1'b1;
          gnt_idx[o] = idx;
        end
      end
    end
  end

  always_comb begin
    bus.rdreq = '0;
    bus.sel   = '0;
    for (int o = 0; o < N_PORTS; o++) begin
      xfer[o] = busy[o] && bus.head_valid[owner[o]] &&
        bus.out_ready[o];
      done[o] = xfer[o] && bus.head_eop[owner[o]];
      if (busy[o]) begin
        bus.sel[o*PORT_W +: PORT_W] = owner[o];
      end
      if (xfer[o]) begin
        bus.rdreq[owner[o]] = 1'b1;
      end
    end
  end

  assign bus.en = busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= '0;
      for (int o = 0; o < N_PORTS; o++) begin
        owner[o] <= '0;
        ptr[o]   <= '0;
      end
    end else begin
      for (int o = 0; o < N_PORTS; o++) begin
        if (busy[o]) begin
          if (done[o]) begin
            busy[o] <= 1'b0;
            ptr[o]  <= owner[o] + PORT_W'(1);
          end
        end else if (gnt_vld[o]) begin
          busy[o]  <= 1'b1;
          owner[o] <= gnt_idx[o];
        end
      end
    end
  end

  for (genvar i = 0; i < N_PORTS; i++) begin : g_chk
    a_one_owner: assert property (
      @(posedge clk) disable iff (reset) $onehot0(own_map[i]));
  end

endmodule

// File: tb/tb_switch_rr_scheduler.sv
// Directed bench for switch_rr_scheduler, N_PORTS=4.
// Small per-input FIFO model pops on rdreq; outputs checked at negedge.
module tb_switch_rr_scheduler;

  typedef struct packed {
    logic [1:0] dest;
    logic       eop;
  } word_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  switch_rr_scheduler_if #(.N_PORTS(4)) bus ();

  switch_rr_scheduler #(.N_PORTS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  word_t      mem [4][16];
  logic [3:0] rp [4];
  logic [3:0] wp [4];
  logic [3:0] bub;
  logic [3:0] ready_v;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] en,
                         input logic [7:0] sel, input logic [3:0] rd);
    chk({tag, "_en"}, 32'(bus.en), 32'(en));
    chk({tag, "_sel"}, 32'(bus.sel), 32'(sel));
    chk({tag, "_rd"}, 32'(bus.rdreq), 32'(rd));
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) begin
      rp[i] = '0;
      wp[i] = '0;
    end
  endtask

  task automatic push(input int i, input logic [1:0] d, input int n);
    for (int k = 0; k < n; k++) begin
      mem[i][wp[i]] = '{dest: d, eop: (k == n - 1)};
      wp[i] = wp[i] + 4'd1;
    end
  endtask

  task automatic drive();
    word_t w;
    for (int i = 0; i < 4; i++) begin
      w = mem[i][rp[i]];
      bus.head_valid[i] = (rp[i] != wp[i]) && !bub[i];
      bus.head_dest[i*2 +: 2] = bub[i] ? ~w.dest : w.dest;
      bus.head_eop[i] = w.eop;
    end
    bus.out_ready = ready_v;
  endtask

  // Commit this cycle's pops at the edge, then present the next heads
  task automatic tick();
    logic [3:0] r;
    r = bus.rdreq;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (r[i]) rp[i] = rp[i] + 4'd1;
    end
    drive();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int order [6];
    order = '{0, 1, 3, 0, 1, 3};
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 16; k++) mem[i][k] = '0;
    end
    bub = '0;
    ready_v = 4'hF;
    flush();
    drive();
    tick();
    tick();
    reset = 1'b0;
    chk_out("rst", 4'h0, 8'h00, 4'h0);

    // single 3-word packet, input 2 -> output 1
    push(2, 2'd1, 3);
    drive();
    #1;
    chk_out("t1_c0", 4'h0, 8'h00, 4'h0);
    tick(); chk_out("t1_c1", 4'b0010, 8'h08, 4'b0100);
    tick(); chk_out("t1_c2", 4'b0010, 8'h08, 4'b0100);
    tick(); chk_out("t1_c3", 4'b0010, 8'h08, 4'b0100);
    tick(); chk_out("t1_c4", 4'h0, 8'h00, 4'h0);

    // ptr[1] is now 3: input 3 beats input 2
    push(2, 2'd1, 1);
    push(3, 2'd1, 1);
    drive();
    tick(); chk_out("ptr_a", 4'b0010, 8'h0C, 4'b1000);
    tick(); chk_out("ptr_idle", 4'h0, 8'h00, 4'h0);
    tick(); chk_out("ptr_b", 4'b0010, 8'h08, 4'b0100);
    tick(); chk_out("ptr_end", 4'h0, 8'h00, 4'h0);

    // contention on output 2 from inputs 0, 1, 3
    flush();
    for (int k = 0; k < 2; k++) begin
      push(0, 2'd2, 1);
      push(1, 2'd2, 1);
      push(3, 2'd2, 1);
    end
    drive();
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_out($sformatf("rr%0d", k), 4'b0100,
              8'(order[k]) << 4, 4'(1 << order[k]));
      tick();
      chk_out($sformatf("rr%0d_idle", k), 4'h0, 8'h00, 4'h0);
    end

    // backpressure: input 1 -> output 0, 4 words
    flush();
    push(1, 2'd0, 4);
    drive();
    tick(); chk_out("bp_w1", 4'b0001, 8'h01, 4'b0010);
    tick(); chk_out("bp_w2", 4'b0001, 8'h01, 4'b0010);
    ready_v = 4'b1110;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", k), 4'b0001, 8'h01, 4'h0);
    end
    ready_v = 4'hF;
    tick(); chk_out("bp_w3", 4'b0001, 8'h01, 4'b0010);
    tick(); chk_out("bp_w4", 4'b0001, 8'h01, 4'b0010);
    tick(); chk_out("bp_end", 4'h0, 8'h00, 4'h0);
    chk("bp_words", 32'(rp[1]), 32'd4);

    // four disjoint paths in parallel
    flush();
    push(0, 2'd3, 3);
    push(1, 2'd2, 3);
    push(2, 2'd1, 3);
    push(3, 2'd0, 3);
    drive();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_out($sformatf("par%0d", k), 4'hF, 8'h1B, 4'hF);
    end
    tick(); chk_out("par_end", 4'h0, 8'h00, 4'h0);

    // bubble on owner with dest toggling; others wait
    flush();
    push(3, 2'd2, 3);
    mem[3][1].dest = 2'd0;
    drive();
    tick(); chk_out("bub_w1", 4'b0100, 8'h30, 4'b1000);
    bub = 4'b1000;
    push(0, 2'd2, 1);
    push(1, 2'd2, 1);
    tick(); chk_out("bub_h0", 4'b0100, 8'h30, 4'h0);
    tick(); chk_out("bub_h1", 4'b0100, 8'h30, 4'h0);
    bub = '0;
    tick(); chk_out("bub_w2", 4'b0100, 8'h30, 4'b1000);
    tick(); chk_out("bub_w3", 4'b0100, 8'h30, 4'b1000);
    tick(); chk_out("bub_idle", 4'h0, 8'h00, 4'h0);
    tick(); chk_out("bub_in0", 4'b0100, 8'h00, 4'b0001);
    tick(); chk_out("bub_idle2", 4'h0, 8'h00, 4'h0);
    tick(); chk_out("bub_in1", 4'b0100, 8'h10, 4'b0010);
    tick(); chk_out("bub_end", 4'h0, 8'h00, 4'h0);

    // reset mid-packet on output 1 (ptr[1] was 3)
    flush();
    push(0, 2'd1, 4);
    drive();
    tick(); chk_out("rm_w1", 4'b0010, 8'h00, 4'b0001);
    tick(); chk_out("rm_w2", 4'b0010, 8'h00, 4'b0001);
    reset = 1'b1;
    tick(); chk_out("rm_rst", 4'h0, 8'h00, 4'h0);
    reset = 1'b0;
    flush();
    push(0, 2'd1, 1);
    push(3, 2'd1, 1);
    drive();
    tick(); chk_out("rm_in0", 4'b0010, 8'h00, 4'b0001);
    tick(); chk_out("rm_idle", 4'h0, 8'h00, 4'h0);
    tick(); chk_out("rm_in3", 4'b0010, 8'h0C, 4'b1000);
    tick(); chk_out("rm_end", 4'h0, 8'h00, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
